// File: rtl/axi3_line_reader.sv
// ---------------------------------------------------------------------------
// axi3_line_reader
//   AXI3 read-burst master for cache-line refills. It accepts one line
//   request, issues one AR burst for a whole line and collects the R beats
//   into a line buffer. Each beat is also streamed out one cycle after it is
//   received, so the cache can restart on the critical word.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_*         line request handshake (byte address of the missing word)
//   word_*        one-cycle pulse per received beat: index within line + data
//   line_*        full line (held until line_ack) and sticky error flag
//   axi3_rd_req   AR channel fields plus rready (master -> interconnect)
//   axi3_rd_resp  arready plus R channel fields (interconnect -> master)
//   arid / rid    constant read ID out; returned ID ignored (one burst only)
// ---------------------------------------------------------------------------
package axi3_line_reader_pkg;

  // 51 bits: AR channel (AXI3 lock reduced to the normal/exclusive bit) + rready
  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axi3_rd_req_t;

  // 37 bits: arready + R channel
  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } axi3_rd_resp_t;

endpackage

module axi3_line_reader
  import axi3_line_reader_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter int         ID_WIDTH   = 4,
  parameter int         ARID       = 0,
  parameter int         WRAP_MODE  = 0,
  parameter logic [3:0] ARCACHE    = 4'b0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  output logic                          word_vld,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx,
  output logic [31:0]                   word_data,
  output logic                          line_vld,
  input  logic                          line_ack,
  output logic [32*LINE_WORDS-1:0]      line_data,
  output logic                          line_err,
  output axi3_rd_req_t                  axi3_rd_req,
  input  axi3_rd_resp_t                 axi3_rd_resp,
  output logic [ID_WIDTH-1:0]           arid,
  input  logic [ID_WIDTH-1:0]           rid
);

  localparam int IW  = $clog2(LINE_WORDS);      // word index width
  localparam int CW  = IW + 1;                  // beat counter must reach LINE_WORDS
  localparam int OFF = $clog2(4 * LINE_WORDS);  // byte offset bits within a line

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [31:0]     r_araddr;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            r_word_vld;
  logic [IW-1:0]   r_word_idx;
  logic [31:0]     r_word_data;
  logic [31:0]     r_buf [LINE_WORDS];

  logic            w_accept;
  logic            w_beat;
  logic            w_final_beat;
  logic            w_last;
  logic            w_early;
  logic            w_arvalid;
  logic            w_rready;
  logic            w_req_ready;
  logic            w_line_vld;
  logic            w_unused;

  // The beat counter holds the number of beats already received, so the
  // beat being accepted now is the last one when the counter is LINE_WORDS-1.
  assign w_final_beat = (r_cnt == CW'(LINE_WORDS - 1));
  assign w_beat       = w_rready && axi3_rd_resp.rvalid;
  assign w_last       = axi3_rd_resp.rlast || w_final_beat;
  assign w_early      = axi3_rd_resp.rlast && !w_final_beat;
  assign w_accept     = w_req_ready && req_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_line_vld   = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = ADDR;
        end
      end
      ADDR: begin
        w_arvalid = 1'b1;
        if (axi3_rd_resp.arready) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        w_rready = 1'b1;
        if (axi3_rd_resp.rvalid && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_line_vld = 1'b1;
        if (line_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------- request / beat state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      if (WRAP_MODE != 0) begin
        // Critical word first: burst starts at the missing word itself.
        r_araddr <= req_addr & ~32'h3;
        r_idx    <= req_addr[OFF-1:2];
      end else begin
        r_araddr <= req_addr & ~32'(4 * LINE_WORDS - 1);
        r_idx    <= '0;
      end
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_beat) begin
      // LINE_WORDS is a power of two, so the natural overflow of r_idx is
      // exactly the modulo wrap a WRAP burst needs.
      r_idx <= r_idx + 1'b1;
      r_cnt <= r_cnt + 1'b1;
      r_err <= r_err || (axi3_rd_resp.rresp != 2'b00) || w_early;
    end
  end

  // Beat stream, registered one cycle after the R handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_vld  <= 1'b0;
      r_word_idx  <= '0;
      r_word_data <= '0;
    end else begin
      r_word_vld <= w_beat;
      if (w_beat) begin
        r_word_idx  <= r_idx;
        r_word_data <= axi3_rd_resp.rdata;
      end
    end
  end

  // Line buffer: one register per word so the whole line is visible at once.
  // Words not written by a short burst keep whatever they held before.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          r_buf[gi] <= '0;
        end else if (w_beat && (r_idx == IW'(gi))) begin
          r_buf[gi] <= axi3_rd_resp.rdata;
        end
      end
      assign line_data[32*gi +: 32] = r_buf[gi];
    end
  endgenerate

  // ------------------------------------------------------------- outputs
  assign req_ready = w_req_ready;
  assign word_vld  = r_word_vld;
  assign word_idx  = r_word_idx;
  assign word_data = r_word_data;
  assign line_vld  = w_line_vld;
  assign line_err  = w_line_vld && r_err;
  assign arid      = ID_WIDTH'(ARID);

  // AR fields come straight from registers, so they are stable while
  // arvalid waits for arready.
  always_comb begin
    axi3_rd_req         = '0;
    axi3_rd_req.araddr  = r_araddr;
    axi3_rd_req.arlen   = 4'(LINE_WORDS - 1);
    axi3_rd_req.arsize  = 3'b010;
    axi3_rd_req.arburst = (WRAP_MODE != 0) ? 2'b10 : 2'b01;
    axi3_rd_req.arlock  = 1'b0;
    axi3_rd_req.arcache = ARCACHE;
    axi3_rd_req.arprot  = 3'b000;
    axi3_rd_req.arvalid = w_arvalid;
    axi3_rd_req.rready  = w_rready;
  end

  // Only one burst is ever outstanding, so the returned ID carries no information.
  assign w_unused = ^rid;

endmodule
